// File: rtl/exp_pkg.sv
// exp_pkg: shared definitions for the softmax-denominator accumulator.
//   bf16_t          : raw bfloat16 bit pattern
//   BF16_* constants: bias, special exponent and special encodings
//   state_e         : control FSM states of exp_sum_acc
package exp_pkg;

    typedef logic [15:0] bf16_t;

    localparam int    BF16_BIAS       = 127;
    localparam int    BF16_EXP_MAX    = 255;
    localparam int    BF16_MANT_W     = 7;
    localparam bf16_t BF16_MAX_FINITE = 16'h7F7F;
    localparam bf16_t BF16_ZERO       = 16'h0000;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        DRAIN  = 2'd1,
        NORM   = 2'd2,
        OUTPUT = 2'd3
    } state_e;

endpackage

// File: rtl/fixed_to_bf16.sv
// fixed_to_bf16: combinational conversion of an unsigned fixed-point value
// (FRAC fractional bits) into a non-negative bf16, rounding toward zero.
//   val_i : unsigned fixed-point magnitude
//   sat_i : value is known to be out of range; forces the largest finite bf16
//   bf_o  : packed bf16 result
module fixed_to_bf16
    import exp_pkg::*;
#(
    parameter int W    = 64,
    parameter int FRAC = 16
) (
    input  logic [W-1:0] val_i,
    input  logic         sat_i,
    output bf16_t        bf_o
);

    int                     lead;
    logic [BF16_MANT_W-1:0] mant;

    always_comb begin
        lead = 0;
        mant = '0;
        bf_o = BF16_ZERO;

        // Highest set bit wins because later iterations overwrite earlier ones.
        for (int i = 0; i < W; i++) begin
            if (val_i[i]) begin
                lead = i;
            end
        end

        // Align so the 7 bits directly below the leading one land in mant;
        // the cast drops the leading one and everything below the mantissa.
        if (lead >= BF16_MANT_W) begin
            mant = BF16_MANT_W'(val_i >> (lead - BF16_MANT_W));
        end else begin
            mant = BF16_MANT_W'(val_i << (BF16_MANT_W - lead));
        end

        if (sat_i) begin
            bf_o = BF16_MAX_FINITE;
        end else if (val_i != '0) begin
            bf_o = {1'b0, 8'(BF16_BIAS + lead - FRAC), mant};
        end
    end

endmodule

// File: rtl/exp_sum_acc.sv
// exp_sum_acc: streaming accumulator for the softmax denominator.
// Sums a last-delimited vector of non-negative bf16 exp values in a wide
// unsigned fixed-point register and emits one bf16 sum plus beat count.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input beat handshake
//   in_data, in_last     : bf16 exp value, final beat of the vector
//   out_valid/out_ready  : result handshake
//   out_sum, out_count   : bf16 vector sum, number of beats in the vector
module exp_sum_acc
    import exp_pkg::*;
#(
    parameter int ACC_INT  = 48,
    parameter int ACC_FRAC = 16,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_sum,
    output logic [CNT_W-1:0] out_count
);

    localparam int ACC_W   = ACC_INT + ACC_FRAC;
    // Left shift that places {1,mant} (value 1.m * 2^7) onto the fixed-point grid.
    localparam int SH_OFF  = BF16_BIAS + BF16_MANT_W - ACC_FRAC;
    // Smallest biased exponent whose value reaches 2^ACC_INT.
    localparam int SAT_EXP = BF16_BIAS + ACC_INT;

    state_e             state_q, state_d;
    logic               in_fire, out_fire;

    logic [7:0]         b_exp;
    logic [ACC_W-1:0]   mant_ext;
    logic [ACC_W-1:0]   conv_val;
    logic               conv_sat;
    int                 shamt;

    logic               s1_vld_q;
    logic               s1_sat_q;
    logic [ACC_W-1:0]   s1_val_q;

    logic [ACC_W:0]     acc_sum;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic               sat_q, sat_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    bf16_t              norm_bf;
    logic               out_valid_q, out_valid_d;
    logic [15:0]        out_sum_q, out_sum_d;
    logic [CNT_W-1:0]   out_count_q, out_count_d;

    assign in_ready  = (state_q == ACCUM);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid_q && out_ready;
    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_count_q;

    // ---- Stage 1: bf16 -> unsigned fixed point ----
    always_comb begin
        b_exp    = in_data[14:7];
        mant_ext = ACC_W'({1'b1, in_data[6:0]});
        shamt    = int'(b_exp) - SH_OFF;
        conv_val = '0;
        conv_sat = 1'b0;
        // Negative, zero and denormal inputs contribute nothing.
        if (!in_data[15] && b_exp != 8'd0) begin
            if (b_exp == 8'(BF16_EXP_MAX) || int'(b_exp) >= SAT_EXP) begin
                conv_sat = 1'b1;
            end else if (shamt >= 0) begin
                conv_val = mant_ext << shamt;
            end else begin
                // Right shift truncates below 2^-ACC_FRAC; tiny values become 0.
                conv_val = mant_ext >> (-shamt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s1_sat_q <= 1'b0;
        end else begin
            s1_vld_q <= in_fire;
            s1_sat_q <= in_fire && conv_sat;
        end
    end

    // Data register is qualified by s1_vld_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_val_q <= conv_val;
        end
    end

    // ---- Stage 2: accumulate, count, control ----
    assign acc_sum = {1'b0, acc_q} + {1'b0, s1_val_q};

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        sat_d       = sat_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_count_d = out_count_q;

        if (s1_vld_q) begin
            acc_d = acc_sum[ACC_W-1:0];
            sat_d = sat_q | s1_sat_q | acc_sum[ACC_W];
        end

        if (in_fire && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            ACCUM: begin
                if (in_fire && in_last) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only once the last beat has left stage 1 into acc.
                if (!s1_vld_q) begin
                    state_d = NORM;
                end
            end
            NORM: begin
                out_valid_d = 1'b1;
                out_sum_d   = norm_bf;
                out_count_d = cnt_q;
                state_d     = OUTPUT;
            end
            OUTPUT: begin
                if (out_fire) begin
                    out_valid_d = 1'b0;
                    acc_d       = '0;
                    sat_d       = 1'b0;
                    cnt_d       = '0;
                    state_d     = ACCUM;
                end
            end
            default: begin
                state_d = ACCUM;
            end
        endcase
    end

    // ---- Stage 3: fixed -> bf16 result register ----
    fixed_to_bf16 #(
        .W    (ACC_W),
        .FRAC (ACC_FRAC)
    ) u_fixed_to_bf16 (
        .val_i (acc_q),
        .sat_i (sat_q),
        .bf_o  (norm_bf)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ACCUM;
            acc_q       <= '0;
            sat_q       <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= BF16_ZERO;
            out_count_q <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_count_q <= out_count_d;
        end
    end

endmodule
